// File: rtl/cr_input_pkg.sv
// rtl/cr_input_pkg.sv - shared move direction types and WASD keycode decode
package cr_input_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dec_t;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_NONE = 8'h00;

    // Anything other than W/A/S/D, including the idle code, decodes as "none".
    function automatic key_dec_t key_to_dir(input logic [7:0] code);
        key_dec_t d;
        d.valid = 1'b1;
        d.dir   = DIR_UP;
        case (code)
            KEY_W:    d.dir = DIR_UP;
            KEY_A:    d.dir = DIR_LEFT;
            KEY_S:    d.dir = DIR_DOWN;
            KEY_D:    d.dir = DIR_RIGHT;
            KEY_NONE: d.valid = 1'b0;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/move_queue_if.sv
// rtl/move_queue_if.sv - move handshake bundle between input stage and game logic
interface move_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          MoveValid;
    logic [1:0]    MoveDir;
    logic          MoveAccept;
    logic [CW-1:0] Count;
    logic          Overflow;

    modport master (
        output MoveValid,
        output MoveDir,
        output Count,
        output Overflow,
        input  MoveAccept
    );

    modport slave (
        input  MoveValid,
        input  MoveDir,
        input  Count,
        input  Overflow,
        output MoveAccept
    );
endinterface

// File: rtl/move_queue_fifo.sv
// rtl/move_queue_fifo.sv - circular move FIFO with sticky overflow on dropped pushes
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   pop,
    output logic                   valid,
    output logic [WIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_en;
    logic             push_en;
    logic             drop;

    assign valid    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_en   = pop && valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en  = push && (!full || pop_en);
    assign drop     = push && full && !pop_en;
    assign data_out = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_queue.sv
// rtl/move_queue.sv - WASD press detector feeding a move FIFO; AUTO_REPEAT_EN adds held-key repeat
module move_queue
    import cr_input_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_FRAMES = 12
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [7:0]   Keycode,
    input  logic         FrameSync,
    move_queue_if.master mq
);
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("move_queue: DEPTH must be a power of two in 2..16");
    end
    if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
        $error("move_queue: REPEAT_FRAMES must be in 1..255");
    end

    logic [7:0] key_q;
    logic [7:0] key_qq;
    logic       fs_q;
    key_dec_t   dec;
    logic       key_changed;
    logic       press_push;
    logic       rpt_push;
    logic       tick;

    assign dec         = key_to_dir(key_q);
    assign key_changed = (key_q != key_qq);
    // Releases and non-direction codes only move the history along.
    assign press_push  = key_changed && dec.valid;
    assign tick        = FrameSync & ~fs_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_q  <= 8'h00;
            key_qq <= 8'h00;
            fs_q   <= 1'b0;
        end else begin
            key_q  <= Keycode;
            key_qq <= key_q;
            fs_q   <= FrameSync;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] RPT_LAST = 8'(REPEAT_FRAMES - 1);

    logic [7:0] rpt_cnt;

    // Counter is forced clear on any key change, so this never coincides with a press.
    assign rpt_push = tick && !key_changed && dec.valid && (rpt_cnt == RPT_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rpt_cnt <= 8'd0;
        end else if (key_changed || !dec.valid) begin
            rpt_cnt <= 8'd0;
        end else if (tick) begin
            rpt_cnt <= rpt_push ? 8'd0 : rpt_cnt + 8'd1;
        end
    end
`else
    logic unused_tick;

    assign rpt_push    = 1'b0;
    assign unused_tick = tick;
`endif

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .push     (press_push || rpt_push),
        .data_in  (dec.dir),
        .pop      (mq.MoveAccept),
        .valid    (mq.MoveValid),
        .data_out (mq.MoveDir),
        .count    (mq.Count),
        .overflow (mq.Overflow)
    );

endmodule

// File: tb/tb_move_queue.sv
// tb/tb_move_queue.sv - scoreboard bench for move_queue press detect, FIFO and reset
module tb_move_queue;

    localparam int DEPTH = 4;
`ifdef AUTO_REPEAT_EN
    localparam int RF = 3;
`else
    localparam int RF = 12;
`endif

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] keycode    = 8'h00;
    logic       frame_sync = 1'b0;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q [$];
    logic       mdl_ovf  = 1'b0;

    always #5 clk = ~clk;

    move_queue_if #(.DEPTH(DEPTH)) mq ();

    move_queue #(
        .DEPTH         (DEPTH),
        .REPEAT_FRAMES (RF)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Keycode   (keycode),
        .FrameSync (frame_sync),
        .mq        (mq)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [1:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else mdl_ovf = 1'b1;
    endtask

    task automatic apply_reset();
        keycode       = 8'h00;
        frame_sync    = 1'b0;
        mq.MoveAccept = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        exp_q.delete();
        mdl_ovf = 1'b0;
    endtask

    task automatic press(input logic [7:0] k, input logic [1:0] d);
        keycode = k;
        model_push(d);
        cyc(3);
        keycode = 8'h00;
        cyc(2);
    endtask

    task automatic pop_one(input string name);
        logic [1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, MoveValid=%0d required pop", name, mq.MoveValid);
        end else begin
            e = exp_q.pop_front();
            if (mq.MoveValid !== 1'b1 || mq.MoveDir !== e) begin
                failures++;
                $display("FAIL %s: valid=%0d dir=%0d, required valid=1 dir=%0d",
                         name, mq.MoveValid, mq.MoveDir, e);
            end
        end
        mq.MoveAccept = 1'b1;
        cyc(1);
        mq.MoveAccept = 1'b0;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_one(name);
        checks++;
        if (mq.MoveValid !== 1'b0 || mq.Count !== 3'd0) begin
            failures++;
            $display("FAIL %s_empty: valid=%0d count=%0d, required 0 0", name, mq.MoveValid, mq.Count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        checks++;
        if ({mq.MoveValid, mq.MoveDir, mq.Count, mq.Overflow} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0d dir=%0d count=%0d ovf=%0d, required all 0",
                     mq.MoveValid, mq.MoveDir, mq.Count, mq.Overflow);
        end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_single_press();
        apply_reset();
        keycode = 8'h1A;
        cyc(1);
        checks++;
        if (mq.MoveValid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: valid=%0d, required 0", mq.MoveValid);
        end
        cyc(1);
        model_push(2'd0);
        checks++;
        if (mq.MoveValid !== 1'b1 || mq.MoveDir !== 2'd0 || mq.Count !== 3'd1) begin
            failures++;
            $display("FAIL latency_push: valid=%0d dir=%0d count=%0d, required 1 0 1",
                     mq.MoveValid, mq.MoveDir, mq.Count);
        end
        cyc(100);
        checks++;
        if (mq.Count !== 3'(exp_q.size())) begin
            failures++;
            $display("FAIL held_no_repeat: count=%0d, required %0d", mq.Count, exp_q.size());
        end
        keycode = 8'h00;
        cyc(2);
        drain("single");
    endtask

    task automatic test_overflow();
        apply_reset();
        press(8'h1A, 2'd0);
        press(8'h04, 2'd1);
        press(8'h16, 2'd2);
        press(8'h07, 2'd3);
        press(8'h1A, 2'd0);
        checks++;
        if (mq.Count !== 3'(exp_q.size()) || mq.Overflow !== mdl_ovf) begin
            failures++;
            $display("FAIL overflow_full: count=%0d ovf=%0d, required %0d %0d",
                     mq.Count, mq.Overflow, exp_q.size(), mdl_ovf);
        end
        drain("overflow");
        checks++;
        if (mq.Overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%0d, required 1", mq.Overflow);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        press(8'h1A, 2'd0);
        press(8'h04, 2'd1);
        press(8'h16, 2'd2);
        press(8'h07, 2'd3);
        keycode = 8'h04;
        cyc(1);
        checks++;
        if (mq.MoveDir !== exp_q[0]) begin
            failures++;
            $display("FAIL fullpp_head: dir=%0d, required %0d", mq.MoveDir, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(2'd1);
        mq.MoveAccept = 1'b1;
        cyc(1);
        mq.MoveAccept = 1'b0;
        keycode = 8'h00;
        checks++;
        if (mq.Count !== 3'd4 || mq.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL fullpp_count: count=%0d ovf=%0d, required 4 0", mq.Count, mq.Overflow);
        end
        cyc(2);
        drain("fullpp");
    endtask

    task automatic test_direct_switch();
        apply_reset();
        keycode = 8'h1A;
        model_push(2'd0);
        cyc(3);
        keycode = 8'h07;
        model_push(2'd3);
        cyc(3);
        keycode = 8'h00;
        cyc(2);
        checks++;
        if (mq.Count !== 3'd2) begin
            failures++;
            $display("FAIL switch_count: count=%0d, required 2", mq.Count);
        end
        drain("switch");
        keycode = 8'h1A;
        model_push(2'd0);
        cyc(3);
        keycode = 8'h2C;
        cyc(3);
        keycode = 8'h1A;
        model_push(2'd0);
        cyc(3);
        keycode = 8'h00;
        cyc(2);
        checks++;
        if (mq.Count !== 3'd2) begin
            failures++;
            $display("FAIL nondir_count: count=%0d, required 2", mq.Count);
        end
        drain("nondir");
    endtask

    task automatic test_accept_empty();
        apply_reset();
        mq.MoveAccept = 1'b1;
        cyc(4);
        checks++;
        if (mq.Count !== 3'd0 || mq.MoveValid !== 1'b0) begin
            failures++;
            $display("FAIL accept_empty: count=%0d valid=%0d, required 0 0", mq.Count, mq.MoveValid);
        end
        keycode = 8'h16;
        cyc(2);
        checks++;
        if (mq.Count !== 3'd1 || mq.MoveDir !== 2'd2) begin
            failures++;
            $display("FAIL push_while_accept: count=%0d dir=%0d, required 1 2", mq.Count, mq.MoveDir);
        end
        cyc(1);
        mq.MoveAccept = 1'b0;
        keycode = 8'h00;
        checks++;
        if (mq.Count !== 3'd0) begin
            failures++;
            $display("FAIL pop_after_push: count=%0d, required 0", mq.Count);
        end
        cyc(2);
    endtask

    task automatic test_repeat();
        apply_reset();
        keycode = 8'h07;
        model_push(2'd3);
        cyc(4);
        for (int i = 1; i <= 7; i++) begin
            frame_sync = 1'b1;
            cyc(3);
            frame_sync = 1'b0;
            cyc(3);
`ifdef AUTO_REPEAT_EN
            if (i % RF == 0) model_push(2'd3);
`endif
        end
        checks++;
        if (mq.Count !== 3'(exp_q.size())) begin
            failures++;
            $display("FAIL repeat_count: count=%0d, required %0d", mq.Count, exp_q.size());
        end
        keycode = 8'h00;
        cyc(2);
        drain("repeat");
    endtask

    task automatic test_async_reset();
        apply_reset();
        press(8'h1A, 2'd0);
        press(8'h04, 2'd1);
        keycode = 8'h16;
        model_push(2'd2);
        cyc(3);
        checks++;
        if (mq.Count !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d, required 3", mq.Count);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mq.MoveValid, mq.MoveDir, mq.Count, mq.Overflow} !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%0d dir=%0d count=%0d ovf=%0d, required all 0",
                     mq.MoveValid, mq.MoveDir, mq.Count, mq.Overflow);
        end
        exp_q.delete();
        mdl_ovf = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        model_push(2'd2);
        cyc(5);
        checks++;
        if (mq.Count !== 3'd1 || mq.MoveDir !== 2'd2) begin
            failures++;
            $display("FAIL held_after_reset: count=%0d dir=%0d, required 1 2", mq.Count, mq.MoveDir);
        end
        keycode = 8'h00;
        cyc(2);
        drain("post_reset");
    endtask

    initial begin
        mq.MoveAccept = 1'b0;
        test_reset();
        test_single_press();
        test_overflow();
        test_full_push_pop();
        test_direct_switch();
        test_accept_empty();
        test_repeat();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/move_queue.md
Name: move_queue

Overview:
- Input-conditioning stage between the SoC keycode PIO and the game logic, running on the 50 MHz system clock.
- Detects new WASD presses in the raw 8-bit USB HID keycode and turns each one into a 2-bit move.
- Buffers moves in a small FIFO so that presses arriving between frame updates are neither lost nor duplicated.
- Game logic pops at most what it consumes via a valid/accept handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- REPEAT_FRAMES, 12, frames a direction key must be held before an auto-repeat move is pushed (AUTO_REPEAT_EN only); range 1..255.

Ports:
- Clk  input  1  50 MHz system clock.
- Reset_n  input  1  asynchronous active-low reset.
- Keycode  input  8  raw HID keycode from the SoC; same clock domain, no synchronizer.
- FrameSync  input  1  VGA vertical sync, same clock domain; rising edge = frame tick.
- MoveAccept  input  1  consumer pops the head entry this cycle.
- MoveValid  output  1  FIFO non-empty.
- MoveDir  output  2  head entry: 0 up, 1 left, 2 down, 3 right; 0 when empty.
- Count  output  $clog2(DEPTH)+1  current occupancy.
- Overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (async, Reset_n=0) forces:
  - MoveValid=0, MoveDir=0, Count=0, Overflow=0.
  - Both keycode history registers = 8'h00, repeat counter = 0, FrameSync history register = 0.
- Decode:
  - 8'h1A->up, 8'h04->left, 8'h16->down, 8'h07->right.
  - All other codes, including 8'h00, are "none".
- Keycode pipeline: key_q <= Keycode; key_qq <= key_q every cycle.
- Press event, evaluated at each edge:
  - Condition: key_q != key_qq and decode(key_q) != none.
  - Effect: push decode(key_q).
  - Changes to non-direction codes and releases only update history.
  - Direct switch from one direction to another (e.g. 1A->04) is a new press.
- Latency: a Keycode change sampled at edge N reaches key_q at N; push occurs at N+1; MoveValid=1 is visible after N+1. No empty-FIFO bypass.
- FIFO:
  - Circular, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
  - Count tracks occupancy.
  - Pop occurs when MoveValid && MoveAccept at the edge. MoveAccept while empty is ignored; pointers do not move.
- Push when full:
  - Without a simultaneous pop: new entry dropped, FIFO contents unchanged, Overflow<=1.
  - With a simultaneous pop: both happen, Count unchanged, no overflow.
- Push while empty with MoveAccept=1: only the push takes effect.
- Overflow clears only on reset.
- MoveDir is combinational from the head entry, registered storage; stable while MoveValid=1 and MoveAccept=0.
- Frame tick = FrameSync & ~fs_q, one cycle wide.
- Reset mid-operation discards all queued moves and in-flight edge detection. After release, a key already held is seen as a press, because key_qq=0.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - 8-bit repeat counter clears on any key_q != key_qq, or when decode(key_q)=none.
  - Otherwise it increments on each frame tick.
  - When it reaches REPEAT_FRAMES on a tick, push decode(key_q) and clear the counter. Held keys therefore repeat every REPEAT_FRAMES frames.
  - A repeat push coincident with a press push cannot occur (the counter is clear on a change).
  - Repeat pushes obey the same full/overflow rules.
- Undefined: counter logic absent; only press events push; held keys produce exactly one move.

Decomposition:
- Package cr_input_pkg:
  - dir_t enum (DIR_UP=0, DIR_LEFT=1, DIR_DOWN=2, DIR_RIGHT=3).
  - Keycode constants KEY_W, KEY_A, KEY_S, KEY_D, KEY_NONE.
  - Function key_to_dir returning a valid bit plus dir_t.
- Sub-module move_fifo (parameter DEPTH, WIDTH=2):
  - Ports: push/data_in, pop, valid/data_out, count, overflow.
  - Clear-on-reset and full/empty rules as above.
- move_queue holds the keycode pipeline, frame-tick detect, repeat counter and push arbitration.

Test Plan:
- Reset then Keycode 00->1A held 100 cycles -> MoveValid=1 two cycles after change, MoveDir=0, Count=1; no further pushes (macro off).
- Presses 1A,04,16,07,1A, each separated by 00, with no accept, DEPTH=4 -> Count=4, Overflow=1, pops yield dirs 0,1,2,3.
- FIFO full, simultaneous press and MoveAccept -> Count stays 4, Overflow stays 0, new dir at tail.
- Direct switch 1A->07 without release -> two entries: 0 then 3. Keycode 1A->2C->1A -> two entries, both up.
- AUTO_REPEAT_EN, REPEAT_FRAMES=3, hold 07 across 7 frame ticks -> pushes at press, tick 3, tick 6; Count=3, all dir 3.
- Reset_n pulsed low with Count=3 and key held -> outputs zero immediately (async); after release, one push of the held direction.
